// File: rtl/mips_pkg.sv
// Shared writeback-stage encodings: load extension opcodes, writeback
// source selects and the hardwired zero register index.
package mips_pkg;

    localparam logic [2:0] DMRDOP_LW  = 3'd0;
    localparam logic [2:0] DMRDOP_LB  = 3'd1;
    localparam logic [2:0] DMRDOP_LBU = 3'd2;
    localparam logic [2:0] DMRDOP_LH  = 3'd3;
    localparam logic [2:0] DMRDOP_LHU = 3'd4;

    localparam logic [1:0] M2SEL_ALU = 2'd0;
    localparam logic [1:0] M2SEL_MEM = 2'd1;
    localparam logic [1:0] M2SEL_PC8 = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_load_ext.sv
// Load data extender: picks the addressed byte/half out of the raw
// little-endian memory word and sign- or zero-extends it by load opcode.
// Misaligned halfwords simply ignore address bit 0.
module wb_load_ext
    import mips_pkg::*;
(
    input  logic [31:0] dm_rd_w,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  dmrdopw,
    output logic [31:0] ext_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Lane select followed by extension; unknown opcodes pass the word through.
    always_comb begin
        case (addr_lo)
            2'd0:    lane_byte = dm_rd_w[7:0];
            2'd1:    lane_byte = dm_rd_w[15:8];
            2'd2:    lane_byte = dm_rd_w[23:16];
            default: lane_byte = dm_rd_w[31:24];
        endcase
        lane_half = addr_lo[1] ? dm_rd_w[31:16] : dm_rd_w[15:0];
        case (dmrdopw)
            DMRDOP_LW:  ext_data = dm_rd_w;
            DMRDOP_LB:  ext_data = {{24{lane_byte[7]}}, lane_byte};
            DMRDOP_LBU: ext_data = {24'h0, lane_byte};
            DMRDOP_LH:  ext_data = {{16{lane_half[15]}}, lane_half};
            DMRDOP_LHU: ext_data = {16'h0, lane_half};
            default:    ext_data = dm_rd_w;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage + general register file. Picks the writeback value,
// commits it to a 32x32 array (r0 reads zero), and serves two
// combinational decode read ports.
// Build option WB_BYPASS_EN: same-cycle write-to-read bypass (write-first).
// Without it, reads see only stored contents and the hazard unit must
// forward from wb_data.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] alu_result_w,
    input  logic [DW-1:0] dm_rd_w,
    input  logic [DW-1:0] pc8w,
    input  logic [4:0]    dstw,
    input  logic          rfwrw,
    input  logic [1:0]    m2selw,
    input  logic [2:0]    dmrdopw,
    input  logic [4:0]    rs_addr,
    input  logic [4:0]    rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic [DW-1:0] wb_data,
    output logic          wb_we
);

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] ld_ext;

    wb_load_ext u_load_ext (
        .dm_rd_w  (dm_rd_w),
        .addr_lo  (alu_result_w[1:0]),
        .dmrdopw  (dmrdopw),
        .ext_data (ld_ext)
    );

    // Writeback source mux; reserved select falls back to the ALU result.
    always_comb begin
        case (m2selw)
            M2SEL_MEM: wb_data = ld_ext;
            M2SEL_PC8: wb_data = pc8w;
            default:   wb_data = alu_result_w;
        endcase
        wb_we = rfwrw && (dstw != REG_ZERO);
    end

    // Register array: async clear, write gated so r0 is never touched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_we) begin
            regs[dstw] <= wb_data;
        end
    end

    // Read ports: zero in reset or for r0, optional write-first bypass.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (reset) begin
            if (rs_addr != REG_ZERO)
                rs_data = (BYPASS && wb_we && rs_addr == dstw) ? wb_data : regs[rs_addr];
            if (rt_addr != REG_ZERO)
                rt_data = (BYPASS && wb_we && rt_addr == dstw) ? wb_data : regs[rt_addr];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed literal checks plus a
// randomized run compared every cycle against an array-based model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] alu_result_w = '0;
    logic [31:0] dm_rd_w = '0;
    logic [31:0] pc8w = '0;
    logic [4:0]  dstw = '0;
    logic        rfwrw = 1'b0;
    logic [1:0]  m2selw = '0;
    logic [2:0]  dmrdopw = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [31:0] rs_data, rt_data, wb_data;
    logic        wb_we;

    int total = 0;
    int bad = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic [31:0] model [32];

    wb_regfile dut (
        .clk          (clk),
        .reset        (reset),
        .alu_result_w (alu_result_w),
        .dm_rd_w      (dm_rd_w),
        .pc8w         (pc8w),
        .dstw         (dstw),
        .rfwrw        (rfwrw),
        .m2selw       (m2selw),
        .dmrdopw      (dmrdopw),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .wb_data      (wb_data),
        .wb_we        (wb_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: writeback value from plain shift/mask arithmetic.
    function automatic logic [31:0] f_wb(input logic [1:0] sel, input logic [2:0] op,
                                         input logic [31:0] a, input logic [31:0] d,
                                         input logic [31:0] p);
        logic [31:0] b, h, ld;
        b = (d >> (8 * int'(a[1:0]))) & 32'hFF;
        h = (d >> (16 * int'(a[1]))) & 32'hFFFF;
        case (op)
            3'd1:    ld = (b ^ 32'h80) - 32'h80;
            3'd2:    ld = b;
            3'd3:    ld = (h ^ 32'h8000) - 32'h8000;
            3'd4:    ld = h;
            default: ld = d;
        endcase
        if (sel == 2'd1) return ld;
        if (sel == 2'd2) return p;
        return a;
    endfunction

    function automatic logic [31:0] f_rd(input logic [4:0] addr);
        logic we;
        we = rfwrw && dstw != 5'd0;
        if (!reset || addr == 5'd0) return 32'h0;
        if (BYP && we && addr == dstw) return f_wb(m2selw, dmrdopw, alu_result_w, dm_rd_w, pc8w);
        return model[addr];
    endfunction

    // Model state: cleared asynchronously, updated on each edge out of reset.
    initial for (int i = 0; i < 32; i++) model[i] = '0;
    always @(negedge reset) for (int i = 0; i < 32; i++) model[i] = '0;
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (rfwrw && dstw != 5'd0) begin
            model[dstw] = f_wb(m2selw, dmrdopw, alu_result_w, dm_rd_w, pc8w);
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_wb_data", wb_data, f_wb(m2selw, dmrdopw, alu_result_w, dm_rd_w, pc8w));
        chk("cyc_wb_we", {31'h0, wb_we}, {31'h0, rfwrw && dstw != 5'd0});
        chk("cyc_rs_data", rs_data, f_rd(rs_addr));
        chk("cyc_rt_data", rt_data, f_rd(rt_addr));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] d, input logic [1:0] sel, input logic [31:0] a);
        rfwrw = 1'b1; dstw = d; m2selw = sel; alu_result_w = a; dmrdopw = 3'd0;
    endtask

    task automatic ld_chk(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] exp);
        rfwrw = 1'b0; m2selw = 2'd1; dmrdopw = op; alu_result_w = a;
        #1;
        chk(name, wb_data, exp);
    endtask

    initial begin
        // Reset state
        rs_addr = 5'd5; rt_addr = 5'd31;
        #2;
        chk("rst_rs", rs_data, 32'h0);
        chk("rst_rt", rt_data, 32'h0);
        step();
        step();
        reset = 1'b1;
        #1;

        // Write r5, then an asynchronous mid-cycle reset clears it
        wr(5'd5, 2'd0, 32'hDEADBEEF);
        step();
        rfwrw = 1'b0; rs_addr = 5'd5;
        #1;
        chk("r5_written", rs_data, 32'hDEADBEEF);
        reset = 1'b0;
        #1;
        chk("r5_async_clr", rs_data, 32'h0);
        reset = 1'b1;
        #1;
        chk("r5_after_rst", rs_data, 32'h0);
        step();

        // r0 write is discarded
        wr(5'd0, 2'd0, 32'h1234);
        #1;
        chk("r0_we", {31'h0, wb_we}, 32'h0);
        step();
        rfwrw = 1'b0; rs_addr = 5'd0;
        #1;
        chk("r0_read", rs_data, 32'h0);

        // Source select
        pc8w = 32'h0040_0008; rs_addr = 5'd3;
        wr(5'd3, 2'd0, 32'h11); step(); rfwrw = 1'b0; #1; chk("sel_alu", rs_data, 32'h11);
        wr(5'd3, 2'd2, 32'h11); step(); rfwrw = 1'b0; #1; chk("sel_pc8", rs_data, 32'h0040_0008);
        wr(5'd3, 2'd3, 32'h11); step(); rfwrw = 1'b0; #1; chk("sel_rsv", rs_data, 32'h11);
        step();

        // Load extension
        dm_rd_w = 32'h80FF_7F01;
        ld_chk("lb_off3",  3'd1, 32'h3, 32'hFFFF_FF80);
        ld_chk("lbu_off3", 3'd2, 32'h3, 32'h0000_0080);
        ld_chk("lb_off1",  3'd1, 32'h1, 32'h0000_007F);
        ld_chk("lh_lo",    3'd3, 32'h0, 32'h0000_7F01);
        ld_chk("lh_hi",    3'd3, 32'h2, 32'hFFFF_80FF);
        ld_chk("lhu_hi",   3'd4, 32'h2, 32'h0000_80FF);
        ld_chk("lh_misal", 3'd3, 32'h3, 32'hFFFF_80FF);
        ld_chk("op6_word", 3'd6, 32'h0, 32'h80FF_7F01);
        step();

        // Same-cycle write/read on r7 (old value 0)
        rs_addr = 5'd7; rt_addr = 5'd7;
        wr(5'd7, 2'd0, 32'hCAFE_0001);
        #1;
        chk("byp_rs_same", rs_data, BYP ? 32'hCAFE_0001 : 32'h0);
        chk("byp_rt_same", rt_data, BYP ? 32'hCAFE_0001 : 32'h0);
        step();
        rfwrw = 1'b0;
        #1;
        chk("byp_rs_next", rs_data, 32'hCAFE_0001);
        chk("byp_rt_next", rt_data, 32'hCAFE_0001);

        // Back-to-back writes with idle cycles carrying junk
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 2'd0, 32'(i) * 32'h0101_0101);
            step();
            if (i % 4 == 0) begin
                rfwrw = 1'b0; dstw = 5'(i); alu_result_w = 32'hFFFF_FFFF;
                step();
            end
        end
        rfwrw = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(31 - i);
            #1;
            chk("b2b_rs", rs_data, 32'(i) * 32'h0101_0101);
            chk("b2b_rt", rt_data, 32'(31 - i) * 32'h0101_0101);
            step();
        end

        // Randomized run against the model
        for (int n = 0; n < 600; n++) begin
            rfwrw        = ($urandom_range(0, 3) != 0);
            dstw         = 5'($urandom_range(0, 31));
            m2selw       = 2'($urandom_range(0, 3));
            dmrdopw      = 3'($urandom_range(0, 7));
            alu_result_w = $urandom;
            dm_rd_w      = $urandom;
            pc8w         = $urandom;
            rs_addr      = ($urandom_range(0, 2) == 0) ? dstw : 5'($urandom_range(0, 31));
            rt_addr      = ($urandom_range(0, 2) == 0) ? dstw : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 49) == 0) begin
                #1 reset = 1'b0;
                #2 reset = 1'b1;
            end
            step();
        end

        rfwrw = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
